// File: rtl/msg_pkg.sv
// Shared types, ASCII constants and message-string lookup for the HEX character stream.
// Latency: none (types and pure functions only).
// Backpressure: n/a; the producer and consumer both import this package.
// Build option: MSG_ZERO_BLANK_EN sends a zero tens digit of the score as a space.
package msg_pkg;

    typedef enum logic [1:0] {
        MSG_NONE  = 2'd0,
        MSG_DEATH = 2'd1,
        MSG_WIN   = 2'd2,
        MSG_SCORE = 2'd3
    } msg_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CONV = 2'd2,
        SEND = 2'd3
    } state_t;

    localparam int SCORE_MAX = 99;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_C  = 8'h43;
    localparam logic [7:0] ASCII_D  = 8'h44;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_H  = 8'h48;
    localparam logic [7:0] ASCII_I  = 8'h49;
    localparam logic [7:0] ASCII_N  = 8'h4E;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_W  = 8'h57;

    localparam logic [2:0] LEN_DEATH = 3'd5;
    localparam logic [2:0] LEN_WIN   = 3'd3;
    localparam logic [2:0] LEN_SCORE = 3'd4;

    function automatic logic [2:0] msg_len(input msg_id_t id);
        logic [2:0] len;
        case (id)
            MSG_DEATH: len = LEN_DEATH;
            MSG_WIN:   len = LEN_WIN;
            MSG_SCORE: len = LEN_SCORE;
            default:   len = 3'd1;
        endcase
        return len;
    endfunction

    function automatic logic [7:0] msg_char(input msg_id_t id, input logic [2:0] idx,
                                            input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] c;
        c = ASCII_SP;
        case (id)
            MSG_DEATH: begin
                case (idx)
                    3'd0:    c = ASCII_D;
                    3'd1:    c = ASCII_E;
                    3'd2:    c = ASCII_A;
                    3'd3:    c = ASCII_T;
                    3'd4:    c = ASCII_H;
                    default: c = ASCII_SP;
                endcase
            end
            MSG_WIN: begin
                case (idx)
                    3'd0:    c = ASCII_W;
                    3'd1:    c = ASCII_I;
                    3'd2:    c = ASCII_N;
                    default: c = ASCII_SP;
                endcase
            end
            MSG_SCORE: begin
                case (idx)
                    3'd0:    c = ASCII_S;
                    3'd1:    c = ASCII_C;
                    3'd2: begin
`ifdef MSG_ZERO_BLANK_EN
                        c = (tens == 4'd0) ? ASCII_SP : (ASCII_0 + {4'h0, tens});
`else
                        c = ASCII_0 + {4'h0, tens};
`endif
                    end
                    3'd3:    c = ASCII_0 + {4'h0, ones};
                    default: c = ASCII_SP;
                endcase
            end
            default: c = ASCII_SP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/score_bcd_seq.sv
// Binary score (clamped to 99) to two BCD digits by repeated subtraction of 10.
// Latency: start in cycle 0 loads the value; done is high tens+1 cycles later (score 99: 10).
// Backpressure: none; digits hold after done until the next start.
// Ports: clk/reset, i_start + i_value (load), o_done (one-cycle pulse), o_tens/o_ones (BCD).
module score_bcd_seq
    import msg_pkg::*;
#(
    parameter int SCORE_W = 7   // must be >= 7 so that 99 is representable
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [SCORE_W-1:0] i_value,
    output logic               o_done,
    output logic [3:0]         o_tens,
    output logic [3:0]         o_ones
);

    localparam logic [SCORE_W-1:0] VALUE_MAX = SCORE_W'(SCORE_MAX);

    logic [6:0] r_rem;
    logic [3:0] r_tens;
    logic       r_run;
    logic [6:0] w_clamped;

    assign w_clamped = (i_value > VALUE_MAX) ? 7'(SCORE_MAX) : 7'(i_value);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem  <= '0;
            r_tens <= '0;
            r_run  <= 1'b0;
        end else if (i_start) begin
            r_rem  <= w_clamped;
            r_tens <= '0;
            r_run  <= 1'b1;
        end else if (r_run) begin
            if (r_rem >= 7'd10) begin
                r_rem  <= r_rem - 7'd10;
                r_tens <= r_tens + 4'd1;
            end else begin
                r_run  <= 1'b0;
            end
        end
    end

    // Done is the cycle in which the remainder is already below 10, so the
    // conversion phase spends exactly tens+1 cycles.
    assign o_done = r_run && (r_rem < 7'd10);
    assign o_tens = r_tens;
    assign o_ones = r_rem[3:0];

endmodule

// File: rtl/msg_stream_writer.sv
// Turns game events (hit/win/score) into ASCII messages sent one char per valid/ready beat.
// Latency: event edge at N -> first char valid after N+2 (score adds tens+1 convert cycles).
// Backpressure: ch_valid holds with data/last/msg_id stable until ch_ready; events queue as pend flags.
// Ports: clk, reset (async, active-high); ev_hit/ev_win/ev_score levels, score;
//        ch_data/ch_valid/ch_last/ch_ready stream; msg_id, busy status.
// Build option: MSG_ZERO_BLANK_EN (see msg_pkg) blanks a zero tens digit.
module msg_stream_writer
    import msg_pkg::*;
#(
    parameter int SCORE_W = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ev_hit,
    input  logic               ev_win,
    input  logic               ev_score,
    input  logic [SCORE_W-1:0] score,
    output logic [7:0]         ch_data,
    output logic               ch_valid,
    output logic               ch_last,
    input  logic               ch_ready,
    output logic [1:0]         msg_id,
    output logic               busy
);

    state_t     r_state, w_next;
    msg_id_t    r_msg_id, w_sel;
    logic [2:0] r_idx;
    logic       r_prev_hit, r_prev_win, r_prev_score;
    logic       r_pend_hit, r_pend_win, r_pend_score;
    logic       w_rise_hit, w_rise_win, w_rise_score;
    logic       w_take_hit, w_take_win, w_take_score;
    logic       w_accept, w_last, w_bcd_start, w_bcd_done;
    logic [3:0] w_tens, w_ones;

    assign w_rise_hit   = ev_hit   & ~r_prev_hit;
    assign w_rise_win   = ev_win   & ~r_prev_win;
    assign w_rise_score = ev_score & ~r_prev_score;

    // Fixed priority hit > win > score among pending requests.
    always_comb begin
        w_sel = MSG_NONE;
        if (r_pend_hit)        w_sel = MSG_DEATH;
        else if (r_pend_win)   w_sel = MSG_WIN;
        else if (r_pend_score) w_sel = MSG_SCORE;
    end

    assign w_take_hit   = (r_state == LOAD) && (w_sel == MSG_DEATH);
    assign w_take_win   = (r_state == LOAD) && (w_sel == MSG_WIN);
    assign w_take_score = (r_state == LOAD) && (w_sel == MSG_SCORE);
    assign w_bcd_start  = w_take_score;

    assign w_accept = (r_state == SEND) && ch_ready;
    assign w_last   = (r_idx == (msg_len(r_msg_id) - 3'd1));

    score_bcd_seq #(.SCORE_W(SCORE_W)) u_bcd (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_bcd_start),
        .i_value (score),
        .o_done  (w_bcd_done),
        .o_tens  (w_tens),
        .o_ones  (w_ones)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_pend_hit || r_pend_win || r_pend_score) w_next = LOAD;
            LOAD:    w_next = (w_sel == MSG_SCORE) ? CONV : SEND;
            CONV:    if (w_bcd_done) w_next = SEND;
            SEND:    if (w_accept && w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ch_valid = 1'b0;
        ch_last  = 1'b0;
        ch_data  = ASCII_SP;
        busy     = (r_state != IDLE);
        if (r_state == SEND) begin
            ch_valid = 1'b1;
            ch_last  = w_last;
            ch_data  = msg_char(r_msg_id, r_idx, w_tens, w_ones);
        end
    end

    assign msg_id = r_msg_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_hit   <= 1'b0;
            r_prev_win   <= 1'b0;
            r_prev_score <= 1'b0;
            r_pend_hit   <= 1'b0;
            r_pend_win   <= 1'b0;
            r_pend_score <= 1'b0;
            r_msg_id     <= MSG_NONE;
            r_idx        <= '0;
        end else begin
            r_prev_hit   <= ev_hit;
            r_prev_win   <= ev_win;
            r_prev_score <= ev_score;
            // A new edge in the same cycle the flag is consumed must survive.
            r_pend_hit   <= (r_pend_hit   & ~w_take_hit)   | w_rise_hit;
            r_pend_win   <= (r_pend_win   & ~w_take_win)   | w_rise_win;
            r_pend_score <= (r_pend_score & ~w_take_score) | w_rise_score;
            if (r_state == LOAD) begin
                r_msg_id <= w_sel;
                r_idx    <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_msg_id <= MSG_NONE;
                    r_idx    <= '0;
                end else begin
                    r_idx    <= r_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_msg_stream_writer.sv
// Bench for msg_stream_writer: request/priority model with per-cycle output compare.
// Latency: n/a.
// Backpressure: drives ch_ready directly, including stalls.
module tb_msg_stream_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ev_hit = 1'b0, ev_win = 1'b0, ev_score = 1'b0;
    logic [6:0] score = '0;
    logic [7:0] ch_data;
    logic       ch_valid, ch_last;
    logic       ch_ready = 1'b1;
    logic [1:0] msg_id;
    logic       busy;

    msg_stream_writer #(.SCORE_W(7)) dut (
        .clk(clk), .reset(reset), .ev_hit(ev_hit), .ev_win(ev_win), .ev_score(ev_score),
        .score(score), .ch_data(ch_data), .ch_valid(ch_valid), .ch_last(ch_last),
        .ch_ready(ch_ready), .msg_id(msg_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_str(input string nm, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
        end
    endtask

    // Expected string for a message, straight from the message rules.
    function automatic string model_str(input int id, input int sc);
        int    v;
        string t;
        v = (sc > 99) ? 99 : sc;
        if (id == 1) return "DEATH";
        if (id == 2) return "WIN";
`ifdef MSG_ZERO_BLANK_EN
        t = (v / 10 == 0) ? " " : $sformatf("%0d", v / 10);
`else
        t = $sformatf("%0d", v / 10);
`endif
        return {"SC", t, $sformatf("%0d", v % 10)};
    endfunction

    // Model state: pending requests (index 0 hit, 1 win, 2 score) with the cycle they become visible.
    bit    m_prev[3];
    bit    m_pend[3];
    int    m_pcyc[3];
    bit    m_act;
    int    m_id, m_pos, m_first, m_idle_from;
    string m_str;

    // Received messages, reassembled purely from accepted beats.
    string r_buf;
    int    r_first;
    string rq[$];
    int    rfirst_q[$], rlast_q[$], rid_q[$];

    always @(negedge clk) begin
        int sel;
        int v;
        logic evs[3];
        evs[0] = ev_hit; evs[1] = ev_win; evs[2] = ev_score;
        if (reset) begin
            chk("rst_valid", ch_valid, 1'b0);
            chk("rst_last", ch_last, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_msg_id", msg_id, 2'd0);
            chk("rst_data", ch_data, 8'h20);
            for (int i = 0; i < 3; i++) begin
                m_prev[i] = 1'b0;
                m_pend[i] = 1'b0;
            end
            m_act = 1'b0;
            m_idle_from = 0;
            r_buf = "";
        end else begin
            if (m_act && cyc >= m_first) begin
                chk("valid", ch_valid, 1'b1);
                chk("data", ch_data, 32'(m_str.getc(m_pos)));
                chk("last", ch_last, (m_pos == m_str.len() - 1) ? 1 : 0);
                chk("msg_id", msg_id, 32'(m_id));
                chk("busy", busy, 1'b1);
                if (ch_ready) begin
                    m_pos++;
                    if (m_pos == m_str.len()) begin
                        m_act = 1'b0;
                        m_idle_from = cyc + 1;
                    end
                end
            end else if (m_act) begin
                chk("valid_prep", ch_valid, 1'b0);
                chk("busy_prep", busy, 1'b1);
            end else begin
                chk("valid_idle", ch_valid, 1'b0);
                chk("busy_idle", busy, 1'b0);
                chk("last_idle", ch_last, 1'b0);
                chk("msg_id_idle", msg_id, 2'd0);
                chk("data_idle", ch_data, 8'h20);
            end
            if (ch_valid && ch_ready) begin
                if (r_buf.len() == 0) begin
                    r_first = cyc;
                    rid_q.push_back(int'(msg_id));
                end
                r_buf = {r_buf, $sformatf("%c", ch_data)};
                if (ch_last) begin
                    rq.push_back(r_buf);
                    rfirst_q.push_back(r_first);
                    rlast_q.push_back(cyc);
                    r_buf = "";
                end
            end
            // Start of the next message: highest priority request already visible while idle.
            sel = -1;
            if (!m_act && m_idle_from <= cyc)
                for (int i = 0; i < 3; i++)
                    if (sel < 0 && m_pend[i] && m_pcyc[i] <= cyc) sel = i;
            if (sel >= 0) begin
                m_pend[sel] = 1'b0;
                m_act   = 1'b1;
                m_id    = sel + 1;
                m_pos   = 0;
                m_str   = model_str(m_id, int'(score));
                v       = (int'(score) > 99) ? 99 : int'(score);
                m_first = (m_id == 3) ? cyc + 3 + v / 10 : cyc + 2;
            end
            for (int i = 0; i < 3; i++) begin
                if (evs[i] && !m_prev[i] && !m_pend[i]) begin
                    m_pend[i] = 1'b1;
                    m_pcyc[i] = cyc + 1;
                end
                m_prev[i] = evs[i];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise the selected events for one cycle; t0 is the cycle count when they went high.
    task automatic pulse(input logic [2:0] m, output int t0);
        ev_hit = m[0]; ev_win = m[1]; ev_score = m[2];
        t0 = cyc;
        tick(1);
        ev_hit = 1'b0; ev_win = 1'b0; ev_score = 1'b0;
    endtask

    task automatic wait_msgs(input int n, input int budget);
        int k;
        k = 0;
        while (rq.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("msg_timeout", (rq.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic clear_log();
        rq.delete(); rfirst_q.delete(); rlast_q.delete(); rid_q.delete();
    endtask

    initial begin
        int t0;
        #1 reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);

        // 1: single DEATH at full rate.
        clear_log();
        pulse(3'b001, t0);
        wait_msgs(1, 30);
        if (rq.size() >= 1) begin
            chk_str("t1_str", rq[0], "DEATH");
            chk("t1_first", rfirst_q[0], t0 + 3);
            chk("t1_last", rlast_q[0], t0 + 7);
            chk("t1_id", rid_q[0], 1);
        end
        tick(3);

        // 2: score 42 with a 3-cycle stall on "C".
        clear_log();
        score = 7'd42;
        tick(1);
        pulse(3'b100, t0);
        tick(t0 + 9 - cyc);
        chk("t2_stall_data", ch_data, 8'h43);
        ch_ready = 1'b0;
        tick(3);
        ch_ready = 1'b1;
        wait_msgs(1, 30);
        if (rq.size() >= 1) begin
            chk_str("t2_str", rq[0], "SC42");
            chk("t2_first", rfirst_q[0], t0 + 8);
            chk("t2_last", rlast_q[0], t0 + 14);
        end
        tick(3);

        // 3: all three events together, served hit, win, score.
        clear_log();
        score = 7'd13;
        tick(1);
        pulse(3'b111, t0);
        wait_msgs(3, 60);
        if (rq.size() >= 3) begin
            chk_str("t3_m0", rq[0], "DEATH");
            chk_str("t3_m1", rq[1], "WIN");
            chk_str("t3_m2", rq[2], "SC13");
            chk("t3_first0", rfirst_q[0], t0 + 3);
            chk("t3_gap01", rfirst_q[1], rlast_q[0] + 3);
            chk("t3_gap12", rfirst_q[2], rlast_q[1] + 5);
        end
        tick(3);

        // 4: clamp and single-digit scores.
        clear_log();
        score = 7'd100 + 7'd27;
        tick(1);
        pulse(3'b100, t0);
        wait_msgs(1, 40);
        if (rq.size() >= 1) begin
            chk_str("t4_clamp", rq[0], "SC99");
            chk("t4_first", rfirst_q[0], t0 + 13);
        end
        tick(3);
        clear_log();
        score = 7'd7;
        tick(1);
        pulse(3'b100, t0);
        wait_msgs(1, 30);
        if (rq.size() >= 1) begin
`ifdef MSG_ZERO_BLANK_EN
            chk_str("t4_seven", rq[0], "SC 7");
`else
            chk_str("t4_seven", rq[0], "SC07");
`endif
            chk("t4_first7", rfirst_q[0], t0 + 4);
        end
        tick(3);

        // 5: reset during the third beat of WIN.
        clear_log();
        pulse(3'b010, t0);
        tick(t0 + 5 - cyc);
        chk("t5_beat3", ch_data, 8'h4E);
        #1 reset = 1'b1;
        #1;
        chk("t5_valid", ch_valid, 1'b0);
        chk("t5_last", ch_last, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_msg_id", msg_id, 2'd0);
        chk("t5_data", ch_data, 8'h20);
        tick(2);
        reset = 1'b0;
        tick(12);
        chk("t5_no_msg", rq.size(), 0);
        chk("t5_idle", busy, 1'b0);

        // 6: two re-pulses during DEATH merge into one more DEATH.
        clear_log();
        pulse(3'b001, t0);
        tick(3);
        pulse(3'b001, t0 == 0 ? t0 : t0);
        tick(1);
        begin
            int tdummy;
            pulse(3'b001, tdummy);
        end
        wait_msgs(2, 40);
        tick(15);
        chk("t6_count", rq.size(), 2);
        if (rq.size() >= 2) begin
            chk_str("t6_m0", rq[0], "DEATH");
            chk_str("t6_m1", rq[1], "DEATH");
            chk("t6_first1", rfirst_q[1], rlast_q[0] + 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
